// File: rtl/key_step_conditioner.sv
// Pushbutton/switch front end for the mod-10 counter: synchronises KEY and w1/w0,
// debounces the key and emits one Step strobe with a captured command per press.
module key_step_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic Clock,
    input  logic Reset,
    input  logic KeyN,
    input  logic SwW1,
    input  logic SwW0,
    output logic Step,
    output logic W1,
    output logic W0,
    output logic KeyState
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta, key_sync;
    logic [1:0]       sw_meta, sw_sync;
    logic             key_p;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             step_nxt, w1_nxt, w0_nxt;

    // Key synchroniser idles at 1 so reset looks like a released button
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= KeyN;
            key_sync <= key_meta;
            sw_meta  <= {SwW1, SwW0};
            sw_sync  <= sw_meta;
        end
    end

    assign key_p = ~key_sync;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            Step  <= 1'b0;
            W1    <= 1'b0;
            W0    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Step  <= step_nxt;
            W1    <= w1_nxt;
            W0    <= w0_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_nxt  = 1'b0;
        w1_nxt    = W1;
        w0_nxt    = W0;
        case (state)
            IDLE: begin
                if (key_p) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_p) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    step_nxt  = 1'b1;
                    w1_nxt    = sw_sync[1];
                    w0_nxt    = sw_sync[0];
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!key_p) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_p) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign KeyState = (state == HELD) || (state == RELEASE_WAIT);

endmodule

// File: doc/key_step_conditioner.md
Name: key_step_conditioner

Overview:
Front-end conditioner for the mod-10 up/down counter FSM on the DE-series board. It synchronises the raw KEY pushbutton and the two command switches (w1, w0) to the 50 MHz system clock, then debounces the key. For each genuine key press it emits exactly one single-cycle Step strobe, together with a registered w1w0 command. The counter FSM consumes Step as its advance enable and W1/W0 as its command, so every state change happens in the system clock domain.

Parameters:
DEBOUNCE_CYCLES, 1000000, number of consecutive stable samples required to accept a press or release (20 ms at 50 MHz); must be >= 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1

Ports:
Clock  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
KeyN  input  1  raw pushbutton, active-low (0 = pressed), asynchronous and bouncy
SwW1  input  1  raw command switch w1, asynchronous
SwW0  input  1  raw command switch w0, asynchronous
Step  output  1  one-cycle pulse per accepted press
W1  output  1  command bit w1, captured on the Step cycle
W0  output  1  command bit w0, captured on the Step cycle
KeyState  output  1  debounced key level (1 = pressed)

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low, with the clock and reset ports named Clock and Reset.
- Reset values:
  - State = IDLE, counter = 0.
  - Step = 0, W1 = 0, W0 = 0, KeyState = 0.
  - Key synchroniser flops = 1 (released); switch synchroniser flops = 0.
- Synchronisation: two-flop synchroniser on each of KeyN, SwW1, SwW0. Internal key_p = NOT(synchronised KeyN). All FSM decisions use the synchronised signals only.
- IDLE (KeyState = 0):
  - key_p = 1 -> PRESS_WAIT, counter <= 0.
  - Otherwise stay.
- PRESS_WAIT (KeyState = 0):
  - key_p = 0 -> IDLE (bounce rejected, no Step).
  - key_p = 1 and counter = DEBOUNCE_CYCLES-1 -> HELD. On that edge: Step <= 1, W1 <= synced SwW1, W0 <= synced SwW0.
  - Otherwise counter <= counter + 1.
- HELD (KeyState = 1):
  - key_p = 0 -> RELEASE_WAIT, counter <= 0.
  - Otherwise stay. No further Steps while held (no auto-repeat).
- RELEASE_WAIT (KeyState = 1):
  - key_p = 1 -> HELD (release bounce rejected, no Step).
  - key_p = 0 and counter = DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise counter <= counter + 1.
- Step is registered. It is high for exactly the one cycle in which the FSM first occupies HELD, and is cleared on the next edge.
- Latency: with KeyN low and stable, Step is high after rising edge DEBOUNCE_CYCLES+3, counted from the first edge that samples KeyN low.
  - Two edges go to the synchroniser, one to the IDLE->PRESS_WAIT transition, and DEBOUNCE_CYCLES to the count.
- W1/W0 hold their value between Steps. Switch changes at any other time have no effect on W1/W0.
- Counter holds its value outside PRESS_WAIT and RELEASE_WAIT. It never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- Reset asserted mid-operation: immediate return to reset values and no Step.
  - If the key is still held after Reset deasserts, it is treated as a new press. One Step follows DEBOUNCE_CYCLES+3 edges later.
- Unreachable state encodings -> IDLE with counter = 0 on the next edge.

Test Plan:
- DEBOUNCE_CYCLES=4, SwW1=1, SwW0=0; drop KeyN low and hold -> Step=1 for one cycle after edge 7; W1W0=10; KeyState=1 from then on.
- Pulse KeyN low for 3 clocks, then high (DEBOUNCE_CYCLES=4) -> no Step; KeyState stays 0; FSM back in IDLE.
- Hold KeyN low for 50 clocks -> exactly one Step. Toggle switches to 11 mid-hold -> W1W0 remains 10.
- Release with bounce: KeyN high for 2 clocks, low for 1, then high stable -> no second Step; KeyState falls 4+ edges after the last bounce has passed the synchroniser.
- Second clean press with SwW1=1, SwW0=1 -> one Step and W1W0=11. Repeat 9 presses with 01 -> exactly 9 Steps counted.
- Assert Reset during PRESS_WAIT at count 2 -> all outputs 0 immediately. Release Reset with the key still held -> Step after 7 edges.
